// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the MiniUart transmit scheduler.
//   - scheduler FSM state encodings (IDLE=0, LOAD=1, BUSY=2)
//   - default FIFO depth / address width
//   - baud counter width
`timescale 1ns/1ps
package uart_tx_sched_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;
  localparam int BAUD_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous DEPTH x 8 byte FIFO for the transmit scheduler.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write din at the rising edge (ignored when full)
//   pop, dout   : dout shows the head byte; pop advances past it (ignored when empty)
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
`timescale 1ns/1ps
module tx_fifo
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // Pointers carry one extra bit so full and empty differ at equal low bits.
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin arbitration of NREQ byte sources into a
// byte FIFO, load sequencing into the transmitter, and baud tick generation.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : requester i has a byte pending
//   req_data  : byte of requester i in bits [8i+7:8i]
//   gnt       : one-hot grant; the granted byte is pushed at this edge
//   baud_div  : baud period minus 1, in clk cycles
//   ts        : transmitter idle status (1 = idle)
//   load      : one-cycle pulse loading d_out into the transmitter
//   d_out     : byte for the transmitter, valid while load=1
//   en_tx     : one-cycle baud tick
//   count     : FIFO occupancy
//   busy      : FIFO non-empty or scheduler not idle
`timescale 1ns/1ps
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  input  logic [BAUD_W-1:0]   baud_div,
  input  logic                ts,
  output logic                load,
  output logic [7:0]          d_out,
  output logic                en_tx,
  output logic [AW:0]         count,
  output logic                busy
);

  sched_state_t      state;
  logic [1:0]        rr_ptr;
  int unsigned       gidx;
  logic              any_gnt;
  logic [7:0]        push_data;
  logic              pop;
  logic              full;
  logic              empty;
  logic [7:0]        fifo_dout;
  logic [BAUD_W-1:0] baud_cnt;

  // Round-robin search: outer loop walks distance from rr_ptr so the first
  // hit is the nearest requester at or after the pointer.
  always_comb begin
    gnt       = '0;
    any_gnt   = 1'b0;
    gidx      = 0;
    push_data = '0;
    if (!full && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!any_gnt && req[i] && (i == (32'(rr_ptr) + k) % NREQ)) begin
            gnt[i]    = 1'b1;
            any_gnt   = 1'b1;
            gidx      = i;
            push_data = req_data[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (any_gnt)
      rr_ptr <= 2'((gidx + 1) % NREQ);
  end

  tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (any_gnt),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign pop = (state == ST_IDLE) && !empty && ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      d_out <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          d_out <= fifo_dout;
          state <= ST_LOAD;
        end
        ST_LOAD: state <= ST_BUSY;
        ST_BUSY: if (ts) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign load = (state == ST_LOAD);
  assign busy = !empty || (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      baud_cnt <= '0;
    else if (baud_cnt == '0)
      baud_cnt <= baud_div;
    else
      baud_cnt <= baud_cnt - BAUD_W'(1);
  end

  // Counter sits at 0 during reset; masking keeps en_tx low until release,
  // so the first tick lands in the first cycle after reset.
  assign en_tx = (baud_cnt == '0) && !rst;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=2, DEPTH=8).
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     gnt;
  logic [15:0]         baud_div;
  logic                ts;
  logic                load;
  logic [7:0]          d_out;
  logic                en_tx;
  logic [AW:0]         count;
  logic                busy;

  uart_tx_sched #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .baud_div (baud_div),
    .ts       (ts),
    .load     (load),
    .d_out    (d_out),
    .en_tx    (en_tx),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  logic [7:0] mq[$];
  int         m_rr;
  bit         m_load;
  bit         m_wait;
  logic [7:0] m_dout;
  int         m_next_tick;

  // stimulus controls
  int         budget [NREQ];
  int         data_mode;
  logic [7:0] fixed_b [NREQ];
  int         ctr;
  bit         ts_hold_low;
  bit         rand_frame;
  bit         rand_gap;
  int         frame_len;
  int         tx_left;

  // sampled DUT outputs and logs
  logic [NREQ-1:0] s_gnt;
  logic            s_load, s_en, s_busy;
  logic [7:0]      s_dout;
  logic [AW:0]     s_count;
  int              tick_cnt;
  int              lcyc;
  logic [7:0]      dlog[$];
  logic [NREQ-1:0] glog[$];
  int              gcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int gi;
    logic [NREQ-1:0] exp_gnt;
    bit exp_en, pop, new_wait;
    cyc++;
    if (rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_load", load, 0);
      chk("rst_dout", d_out, 0);
      chk("rst_en_tx", en_tx, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      m_rr = 0; m_load = 0; m_wait = 0; m_dout = '0;
      m_next_tick = cyc + 1;
      return;
    end
    gi = -1;
    if (mq.size() < DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (gi < 0 && req[idx]) gi = idx;
      end
    exp_gnt = '0;
    if (gi >= 0) exp_gnt[gi] = 1'b1;
    exp_en = (cyc == m_next_tick);
    if (exp_en) m_next_tick = cyc + int'(baud_div) + 1;
    chk("gnt", gnt, exp_gnt);
    chk("count", count, mq.size());
    chk("load", load, m_load);
    chk("busy", busy, (mq.size() != 0) || m_load || m_wait);
    chk("en_tx", en_tx, exp_en);
    if (m_load) chk("d_out", d_out, m_dout);
    // state advance for the coming edge
    pop = !m_load && !m_wait && (mq.size() > 0) && ts;
    if (pop) m_dout = mq.pop_front();
    if (gi >= 0) begin
      mq.push_back(req_data[8*gi +: 8]);
      m_rr = (gi + 1) % NREQ;
    end
    new_wait = m_load || (m_wait && !ts);
    m_load = pop;
    m_wait = new_wait;
  endtask

  function automatic logic [7:0] next_byte(input int i);
    logic [7:0] b;
    case (data_mode)
      1: b = fixed_b[i];
      2: begin b = 8'(ctr); ctr++; end
      default: b = 8'($urandom_range(0, 255));
    endcase
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && s_gnt[i]) req[i] = 1'b0;
      if (!rst && !req[i] && budget[i] > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
        budget[i]--;
        req[i] = 1'b1;
        req_data[8*i +: 8] = next_byte(i);
      end
    end
    if (rst) tx_left = 0;
    else if (s_load) tx_left = rand_frame ? int'($urandom_range(1, 6)) : frame_len;
    if (tx_left > 0) begin
      ts = 1'b0;
      tx_left--;
    end else begin
      ts = !ts_hold_low;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    s_gnt = gnt; s_load = load; s_dout = d_out; s_count = count; s_busy = busy; s_en = en_tx;
    if (s_en) tick_cnt++;
    if (!rst && s_load) begin dlog.push_back(s_dout); lcyc = cyc; end
    if (!rst && s_gnt != 0) begin glog.push_back(s_gnt); gcyc.push_back(cyc); end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    dlog.delete(); glog.delete(); gcyc.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) budget[i] = 0;
    tx_left = 0;
    ts_hold_low = 0;
    ts = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_loads(input int n, input int limit);
    int c = 0;
    while (dlog.size() < n && c < limit) begin step(); c++; end
    chk("loads_within_budget", dlog.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; baud_div = 16'd3; ts = 1'b1;
    data_mode = 0; ctr = 0; ts_hold_low = 0; rand_frame = 0; rand_gap = 0;
    frame_len = 4; tx_left = 0; tick_cnt = 0; lcyc = 0;
    for (int i = 0; i < NREQ; i++) begin budget[i] = 0; fixed_b[i] = '0; end
    s_gnt = '0; s_load = 0; s_en = 0; s_busy = 0; s_dout = '0; s_count = '0;

    // baud generator
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("first_tick_after_reset", s_en, 1);
    tick_cnt = 1;
    repeat (39) step();
    chk("baud_div3_ticks_in_40", tick_cnt, 10);
    baud_div = 16'd0;
    repeat (4) step();
    tick_cnt = 0;
    repeat (10) step();
    chk("baud_div0_ticks_in_10", tick_cnt, 10);
    baud_div = 16'd5;

    // single byte
    do_reset(2);
    data_mode = 1; fixed_b[0] = 8'hA5; frame_len = 20; budget[0] = 1;
    wait_loads(1, 20);
    chk("single_gnt", glog[0], 2'b01);
    chk("single_latency", lcyc - gcyc[0], 2);
    chk("single_dout", dlog[0], 8'hA5);
    repeat (25) step();
    chk("single_no_second_load", dlog.size(), 1);
    chk("single_busy_low", s_busy, 0);

    // round-robin
    do_reset(2);
    fixed_b[0] = 8'h11; fixed_b[1] = 8'h22; frame_len = 2;
    budget[0] = 6; budget[1] = 6;
    wait_loads(12, 300);
    for (int j = 0; j < 6; j++) begin
      chk("rr_gnt", glog[j], (j % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_dout", dlog[j], (j % 2 == 0) ? 8'h11 : 8'h22);
    end

    // full FIFO
    do_reset(2);
    data_mode = 0; ts_hold_low = 1; ts = 1'b0;
    budget[0] = 10; budget[1] = 10;
    repeat (12) step();
    chk("full_grants", glog.size(), 8);
    chk("full_count", s_count, 8);
    chk("full_gnt_zero", s_gnt, 0);
    ts_hold_low = 0; ts = 1'b1;
    step();
    chk("full_gnt_during_pop", s_gnt, 0);
    chk("full_count_during_pop", s_count, 8);
    step();
    chk("regrant_after_pop", s_gnt != 0, 1);
    chk("count_after_pop", s_count, 7);
    frame_len = 1;
    wait_loads(20, 400);

    // reset while BUSY with five queued bytes
    do_reset(2);
    ts_hold_low = 1; ts = 1'b0; budget[0] = 6; frame_len = 30;
    repeat (10) step();
    chk("prefill_count", s_count, 6);
    ts_hold_low = 0;
    wait_loads(1, 5);
    repeat (3) step();
    chk("pre_reset_count", s_count, 5);
    chk("pre_reset_busy", s_busy, 1);
    rst = 1'b1; req = '0;
    step();
    chk("in_reset_load", s_load, 0);
    chk("in_reset_count", s_count, 0);
    chk("in_reset_busy", s_busy, 0);
    chk("in_reset_en_tx", s_en, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_tick", s_en, 1);
    chk("post_reset_count", s_count, 0);

    // pointer wrap-around
    do_reset(2);
    data_mode = 2; ctr = 0; rand_frame = 1; budget[0] = 20;
    wait_loads(20, 500);
    for (int j = 0; j < 20; j++) chk("wrap_order", dlog[j], j);

    // randomized traffic
    do_reset(2);
    data_mode = 0; rand_gap = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (budget[i] == 0 && $urandom_range(0, 7) == 0) budget[i] = int'($urandom_range(1, 6));
      if ($urandom_range(0, 39) == 0) ts_hold_low = !ts_hold_low;
      if ($urandom_range(0, 99) == 0) baud_div = 16'($urandom_range(0, 7));
      step();
    end
    for (int i = 0; i < NREQ; i++) budget[i] = 0;
    ts_hold_low = 0;
    repeat (200) step();
    chk("drained_count", s_count, 0);
    chk("drained_busy", s_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
